// File: rtl/simon_round_core_pkg.sv
// Shared Simon constants: mode encodings, rounds per mode, word sizes and FSM states.
package simon_round_core_pkg;

    localparam logic SIMON_MODE_64_128  = 1'b0;
    localparam logic SIMON_MODE_128_128 = 1'b1;

    localparam logic [6:0] SIMON_64_128_ROUNDS  = 7'd44;
    localparam logic [6:0] SIMON_128_128_ROUNDS = 7'd68;

    localparam int SIMON_64_128_WORD  = 32;
    localparam int SIMON_128_128_WORD = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } simon_state_e;

    function automatic logic [6:0] simon_rounds(input logic mode_sel);
        return (mode_sel == SIMON_MODE_128_128) ? SIMON_128_128_ROUNDS : SIMON_64_128_ROUNDS;
    endfunction

endpackage

// File: rtl/simon_round_core_round_fn.sv
// Simon round mixing term r = a ^ f(b) ^ k with f(v) = (rol1 & rol8) ^ rol2,
// assembled from fixed left-rotate units.
module rotate_unit #(
    parameter int W   = 32,
    parameter int AMT = 1
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    assign dout = {din[W-AMT-1:0], din[W-1:W-AMT]};
endmodule

module simon_round_fn #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] k,
    output logic [W-1:0] r
);
    logic [W-1:0] rol1_s;
    logic [W-1:0] rol2_s;
    logic [W-1:0] rol8_s;

    rotate_unit #(.W(W), .AMT(1)) u_rol1 (.din(b), .dout(rol1_s));
    rotate_unit #(.W(W), .AMT(2)) u_rol2 (.din(b), .dout(rol2_s));
    rotate_unit #(.W(W), .AMT(8)) u_rol8 (.din(b), .dout(rol8_s));

    assign r = a ^ ((rol1_s & rol8_s) ^ rol2_s) ^ k;
endmodule

// File: rtl/simon_round_core.sv
// Iterative Simon 64/128 and 128/128 encrypt/decrypt core, one round per clock,
// fed by the key expander's round-key array.
module simon_round_core
    import simon_round_core_pkg::*;
#(
    parameter int SIMON_MAX_ROUNDS     = 68,
    parameter int SIMON_MAX_WORD_WIDTH = 64,
    parameter int BLOCK_WIDTH          = 128
) (
    input  logic                            ck,
    input  logic                            nrst,
    input  logic [SIMON_MAX_WORD_WIDTH-1:0] round_key [0:SIMON_MAX_ROUNDS-1],
    input  logic                            kexp_valid,
    input  logic                            mode,
    input  logic                            decrypt,
    input  logic [BLOCK_WIDTH-1:0]          block_in,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [BLOCK_WIDTH-1:0]          block_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            key_err
);

    simon_state_e state_r, state_nxt_s;
    logic [6:0]                      cnt_r, cnt_nxt_s;
    logic                            mode_r, mode_nxt_s;
    logic                            dec_r, dec_nxt_s;
    logic [SIMON_MAX_WORD_WIDTH-1:0] x_r, x_nxt_s, y_r, y_nxt_s;
    logic [BLOCK_WIDTH-1:0]          block_out_r, block_out_nxt_s;
    logic                            out_valid_r, out_valid_nxt_s;
    logic                            key_err_r, key_err_nxt_s;

    logic                            in_ready_s;
    logic [6:0]                      rounds_s;
    logic [6:0]                      key_idx_s;
    logic [SIMON_MAX_WORD_WIDTH-1:0] key_s, fn_a_s, fn_b_s, res_s, x_step_s, y_step_s;
    logic [31:0]                     r32_s;
    logic [63:0]                     r64_s;

    assign in_ready_s = (state_r == ST_IDLE) && kexp_valid;
    assign rounds_s   = simon_rounds(mode_r);
    // Decrypt walks the key array backwards so the same counter drives both directions.
    assign key_idx_s  = dec_r ? (rounds_s - 7'd1 - cnt_r) : cnt_r;
    assign key_s      = round_key[key_idx_s];

    // Encrypt mixes f(x) into y; decrypt mixes f(y) into x: swap the operands.
    assign fn_a_s = dec_r ? x_r : y_r;
    assign fn_b_s = dec_r ? y_r : x_r;

    simon_round_fn #(.W(SIMON_64_128_WORD)) u_fn32 (
        .a(fn_a_s[31:0]), .b(fn_b_s[31:0]), .k(key_s[31:0]), .r(r32_s)
    );

    simon_round_fn #(.W(SIMON_128_128_WORD)) u_fn64 (
        .a(fn_a_s), .b(fn_b_s), .k(key_s), .r(r64_s)
    );

    assign res_s    = (mode_r == SIMON_MODE_128_128) ? r64_s : {32'h0000_0000, r32_s};
    assign x_step_s = dec_r ? y_r : res_s;
    assign y_step_s = dec_r ? res_s : x_r;

    // Next-state and datapath update for the IDLE/RUN/DONE controller.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        mode_nxt_s      = mode_r;
        dec_nxt_s       = dec_r;
        x_nxt_s         = x_r;
        y_nxt_s         = y_r;
        block_out_nxt_s = block_out_r;
        out_valid_nxt_s = out_valid_r;
        key_err_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_s) begin
                    mode_nxt_s  = mode;
                    dec_nxt_s   = decrypt;
                    cnt_nxt_s   = 7'd0;
                    state_nxt_s = ST_RUN;
                    if (mode == SIMON_MODE_128_128) begin
                        x_nxt_s = block_in[127:64];
                        y_nxt_s = block_in[63:0];
                    end else begin
                        x_nxt_s = {32'h0000_0000, block_in[63:32]};
                        y_nxt_s = {32'h0000_0000, block_in[31:0]};
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!kexp_valid) begin
                    state_nxt_s   = ST_IDLE;
                    key_err_nxt_s = 1'b1;
                    cnt_nxt_s     = 7'd0;
                    x_nxt_s       = 64'h0;
                    y_nxt_s       = 64'h0;
                end else if (cnt_r == (rounds_s - 7'd1)) begin
                    x_nxt_s         = x_step_s;
                    y_nxt_s         = y_step_s;
                    out_valid_nxt_s = 1'b1;
                    state_nxt_s     = ST_DONE;
                    if (mode_r == SIMON_MODE_128_128) begin
                        block_out_nxt_s = {x_step_s, y_step_s};
                    end else begin
                        block_out_nxt_s = {64'h0, x_step_s[31:0], y_step_s[31:0]};
                    end
                end else begin
                    x_nxt_s   = x_step_s;
                    y_nxt_s   = y_step_s;
                    cnt_nxt_s = cnt_r + 7'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    out_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge ck) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge ck) begin
        if (!nrst) begin
            cnt_r       <= 7'd0;
            mode_r      <= SIMON_MODE_64_128;
            dec_r       <= 1'b0;
            x_r         <= 64'h0;
            y_r         <= 64'h0;
            block_out_r <= 128'h0;
            out_valid_r <= 1'b0;
            key_err_r   <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            mode_r      <= mode_nxt_s;
            dec_r       <= dec_nxt_s;
            x_r         <= x_nxt_s;
            y_r         <= y_nxt_s;
            block_out_r <= block_out_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            key_err_r   <= key_err_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign block_out = block_out_r;
    assign out_valid = out_valid_r;
    assign key_err   = key_err_r;

endmodule

// File: tb/tb_simon_round_core.sv
// Scoreboard bench for simon_round_core using the published Simon test vectors;
// round keys come from a behavioural key-schedule model inside the bench.
module tb_simon_round_core;
    import simon_round_core_pkg::*;

    logic         ck;
    logic         nrst;
    logic [63:0]  rk [0:67];
    logic         kexp_valid;
    logic         mode;
    logic         decrypt;
    logic [127:0] block_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] block_out;
    logic         out_valid;
    logic         out_ready;
    logic         key_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_q [$];
    logic [127:0] exp_t;

    localparam logic [127:0] KEY64  = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [127:0] PT64   = {64'h0, 64'h656b696c_20646e75};
    localparam logic [127:0] CT64   = {64'h0, 64'h44c8fc20_b9dfa07a};
    localparam logic [127:0] KEY128 = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] PT128  = 128'h6373656420737265_6c6c657661727420;
    localparam logic [127:0] CT128  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;

    simon_round_core dut (
        .ck(ck), .nrst(nrst), .round_key(rk), .kexp_valid(kexp_valid),
        .mode(mode), .decrypt(decrypt), .block_in(block_in), .in_valid(in_valid),
        .in_ready(in_ready), .block_out(block_out), .out_valid(out_valid),
        .out_ready(out_ready), .key_err(key_err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] rorn(input logic [63:0] v, input int s, input int n);
        logic [63:0] msk;
        msk = (n == 64) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
        v = v & msk;
        return ((v >> s) | (v << (n - s))) & msk;
    endfunction

    // Reference Simon key schedule; upper bits of 32-bit keys carry junk on purpose.
    task automatic expand(input logic md, input logic [127:0] key);
        int n, m, t;
        string z;
        logic [63:0] kk [0:67];
        logic [63:0] msk, tmp, zb;
        if (md == SIMON_MODE_128_128) begin
            n = 64; m = 2; t = 68;
            z = "10101111011100000011010010011000101000010001111110010110110011";
        end else begin
            n = 32; m = 4; t = 44;
            z = "11011011101011000110010111100000010010001010011100110100001111";
        end
        msk = (n == 64) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
        for (int i = 0; i < 68; i++) kk[i] = 64'h0;
        for (int i = 0; i < m; i++) kk[i] = 64'(key >> (i * n)) & msk;
        for (int i = m; i < t; i++) begin
            tmp = rorn(kk[i-1], 3, n);
            if (m == 4) tmp = tmp ^ kk[i-3];
            tmp = tmp ^ rorn(tmp, 1, n);
            zb  = (z[(i - m) % 62] == 8'h31) ? 64'd1 : 64'd0;
            kk[i] = (~kk[i-m] ^ tmp ^ zb ^ 64'd3) & msk;
        end
        for (int i = 0; i < 68; i++) begin
            if (i < t) rk[i] = (n == 64) ? kk[i] : (kk[i] | 64'hdead_beef_0000_0000);
            else       rk[i] = 64'h0;
        end
    endtask

    // Full transaction: accept, scramble inputs during the run, check latency, optional backpressure.
    task automatic run_block(input logic md, input logic dc, input logic [127:0] blk,
                             input logic [127:0] expv, input int hold);
        int r, c;
        r = (md == SIMON_MODE_128_128) ? 68 : 44;
        @(posedge ck); #1;
        mode = md; decrypt = dc; block_in = blk; in_valid = 1'b1;
        out_ready = (hold == 0);
        check("in_ready_idle", 128'(in_ready), 128'd1);
        exp_q.push_back(expv);
        @(posedge ck); #1;
        in_valid = 1'b0;
        c = 0;
        while (c < r + 20 && !out_valid) begin
            block_in = {$urandom, $urandom, $urandom, $urandom};
            mode = ~mode;
            decrypt = 1'($urandom);
            @(posedge ck); #1;
            c++;
        end
        check("latency", 128'(c), 128'(r));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1; mode = ~mode; decrypt = ~decrypt; block_in = ~block_in;
                @(posedge ck); #1;
                check("bp_block_out", block_out, expv);
                check("bp_out_valid", 128'(out_valid), 128'd1);
                check("bp_in_ready", 128'(in_ready), 128'd0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge ck); #1;
            check("in_ready_after_release", 128'(in_ready), 128'd1);
        end
    endtask

    // Scoreboard monitor: every consumed result must match the oldest expectation.
    always @(negedge ck) begin
        if (nrst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none", block_out);
            end else begin
                exp_t = exp_q.pop_front();
                check("scoreboard_block_out", block_out, exp_t);
            end
        end
    end

    initial begin
        nrst = 1'b0; kexp_valid = 1'b1; mode = SIMON_MODE_64_128; decrypt = 1'b0;
        block_in = 128'h0; in_valid = 1'b0; out_ready = 1'b1;
        expand(SIMON_MODE_64_128, KEY64);
        repeat (2) @(posedge ck);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_block_out", block_out, 128'h0);
        check("rst_key_err", 128'(key_err), 128'd0);
        nrst = 1'b1;

        run_block(SIMON_MODE_64_128, 1'b0, PT64, CT64, 0);
        run_block(SIMON_MODE_64_128, 1'b1, {64'hffff_0000_1234_5678, CT64[63:0]}, PT64, 0);

        // Reset at round 30 of a 64/128 encrypt.
        @(posedge ck); #1;
        mode = SIMON_MODE_64_128; decrypt = 1'b0; block_in = PT64; in_valid = 1'b1;
        @(posedge ck); #1;
        in_valid = 1'b0;
        repeat (30) @(posedge ck);
        #1;
        nrst = 1'b0;
        @(posedge ck); #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_block_out", block_out, 128'h0);
        check("midrst_key_err", 128'(key_err), 128'd0);
        nrst = 1'b1;
        repeat (50) @(posedge ck);
        #1;
        check("midrst_no_output", 128'(out_valid), 128'd0);
        run_block(SIMON_MODE_64_128, 1'b0, PT64, CT64, 0);

        expand(SIMON_MODE_128_128, KEY128);
        run_block(SIMON_MODE_128_128, 1'b0, PT128, CT128, 0);
        run_block(SIMON_MODE_128_128, 1'b1, CT128, PT128, 0);
        run_block(SIMON_MODE_128_128, 1'b0, PT128, CT128, 10);

        // Key loss at round 20 of a 128/128 encrypt.
        @(posedge ck); #1;
        mode = SIMON_MODE_128_128; decrypt = 1'b0; block_in = PT128; in_valid = 1'b1;
        @(posedge ck); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge ck);
        #1;
        kexp_valid = 1'b0;
        in_valid = 1'b1;
        @(posedge ck); #1;
        check("abort_key_err_hi", 128'(key_err), 128'd1);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_in_ready", 128'(in_ready), 128'd0);
        @(posedge ck); #1;
        check("abort_key_err_pulse", 128'(key_err), 128'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge ck); #1;
            check("nokey_in_ready", 128'(in_ready), 128'd0);
            check("nokey_out_valid", 128'(out_valid), 128'd0);
        end
        in_valid = 1'b0;
        kexp_valid = 1'b1;
        #1;
        check("abort_idle_in_ready", 128'(in_ready), 128'd1);
        run_block(SIMON_MODE_128_128, 1'b0, PT128, CT128, 0);

        repeat (3) @(posedge ck);
        #1;
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
